relay_pulse_sequencer: RTL and testbench

RELAY_PULSE_SEQUENCER -- requirements
Module: relay_pulse_sequencer

---
 rtl/relay_pulse_sequencer_pkg.sv | 17 +
 rtl/relay_pulse_sequencer_picker.sv | 28 ++
 rtl/relay_pulse_sequencer.sv | 143 ++++++++++++++
 tb/tb_relay_pulse_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pulse_sequencer_pkg.sv
// Shared types for the relay pulse sequencer: relay count, FSM state encoding
// and a small constant helper used to size the cycle counters.
package CrossbarTypes;

    localparam int NUM_RELAYS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } relay_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relay_pulse_sequencer_picker.sv
// Combinational round-robin picker: searches the request mask starting one
// position after the last grant, wrapping modulo four.
module RoundRobinPicker4
    import CrossbarTypes::*;
(
    input  logic [NUM_RELAYS-1:0] req_mask,
    input  logic [1:0]            last_granted,
    output logic                  grant_valid,
    output logic [1:0]            grant_idx
);

    logic [1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_granted;
        cand        = '0;
        // The last granted channel is visited last (offset 4 wraps to itself).
        for (int i = 1; i <= NUM_RELAYS; i++) begin
            cand = last_granted + 2'(i);
            if (!grant_valid && req_mask[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/relay_pulse_sequencer.sv
// Latching-relay H-bridge sequencer: queues one request per relay, then issues
// one coil pulse at a time followed by an all-off deadtime, round-robin.
module relay_pulse_sequencer
    import CrossbarTypes::*;
#(
    parameter int PULSE_CYCLES    = 1250000,
    parameter int DEADTIME_CYCLES = 125000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // req_valid is a single-cycle strobe that is always accepted; a later
    // strobe for a still-pending channel replaces its queued direction.
    input  logic                  req_valid,
    input  logic [1:0]            req_channel,
    input  logic                  req_state,
    output logic [NUM_RELAYS-1:0] relay_a,
    output logic [NUM_RELAYS-1:0] relay_b,
    output logic [NUM_RELAYS-1:0] relay_state,
    output logic [NUM_RELAYS-1:0] pending,
    output logic                  busy,
    output relay_seq_state_t      fsm_state
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, DEADTIME_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEADTIME_CYCLES - 1);

    relay_seq_state_t      state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            cur_ch_q;
    logic                  cur_dir_q;
    logic [1:0]            last_q;
    logic [NUM_RELAYS-1:0] pending_q;
    logic [NUM_RELAYS-1:0] dir_q;
    logic [NUM_RELAYS-1:0] rs_q;
    logic [NUM_RELAYS-1:0] drive_a, drive_b;
    logic                  pick_valid;
    logic [1:0]            pick_idx;
    logic                  grant;
    logic                  pulse_done;

    RoundRobinPicker4 u_picker (
        .req_mask     (pending_q),
        .last_granted (last_q),
        .grant_valid  (pick_valid),
        .grant_idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_ch_q  <= '0;
            cur_dir_q <= 1'b0;
            last_q    <= 2'd3;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                cur_ch_q  <= pick_idx;
                cur_dir_q <= dir_q[pick_idx];
                last_q    <= pick_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant      = 1'b0;
        pulse_done = 1'b0;
        drive_a    = '0;
        drive_b    = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant   = 1'b1;
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE: begin
                drive_a[cur_ch_q] = cur_dir_q;
                drive_b[cur_ch_q] = ~cur_dir_q;
                if (cnt_q == '0) begin
                    pulse_done = 1'b1;
                    state_d    = DEAD;
                    cnt_d      = DEAD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DEAD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request landing on the grant edge for the same channel is written
    // last, so it survives the grant's clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            dir_q     <= '0;
            rs_q      <= '0;
        end else begin
            if (grant) begin
                pending_q[pick_idx] <= 1'b0;
            end
            if (req_valid) begin
                pending_q[req_channel] <= 1'b1;
                dir_q[req_channel]     <= req_state;
            end
            if (pulse_done) begin
                rs_q[cur_ch_q] <= cur_dir_q;
            end
        end
    end

    // Output stage: every coil and status output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relay_a     <= '0;
            relay_b     <= '0;
            relay_state <= '0;
            busy        <= 1'b0;
        end else begin
            relay_a     <= drive_a;
            relay_b     <= drive_b;
            relay_state <= rs_q;
            busy        <= (state_q != IDLE);
        end
    end

    assign pending   = pending_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_relay_pulse_sequencer.sv
// Bench for relay_pulse_sequencer: directed scenarios plus random requests,
// scored against an event-level model of grants and pulse timing.
module tb_relay_pulse_sequencer;
    import CrossbarTypes::*;

    localparam int P = 8;
    localparam int D = 4;
    localparam int W = 23;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [1:0]       req_channel = '0;
    logic             req_state = 1'b0;
    logic [3:0]       relay_a, relay_b, relay_state, pending;
    logic             busy;
    relay_seq_state_t fsm_state;

    relay_pulse_sequencer #(.PULSE_CYCLES(P), .DEADTIME_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_channel (req_channel),
        .req_state   (req_state),
        .relay_a     (relay_a),
        .relay_b     (relay_b),
        .relay_state (relay_state),
        .pending     (pending),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;

    // Expected pulses: {start_cycle[15:0], relay_state_after[3:0], dir, ch[1:0]}
    logic [W-1:0] exp_q[$];
    int obs_ch[$];
    int obs_start[$];

    logic [3:0] m_pend = '0;
    logic [3:0] m_dir = '0;
    logic [3:0] m_rs = '0;
    int m_last = 3;
    int m_next_grant = 0;
    int m_busy_lo = 0;
    int m_busy_hi = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: a grant can happen on any edge at least P+D+1 edges after the
    // previous one; the grant sees pending state from before the edge, and a
    // request on the same edge is applied afterwards.
    task automatic model_edge(input logic v, input logic [1:0] ch, input logic st);
        int c;
        bit found;
        c = 0;
        found = 0;
        if (cyc >= m_next_grant && m_pend != 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (!found && m_pend[(m_last + k) % 4]) begin
                    found = 1;
                    c = (m_last + k) % 4;
                end
            end
            m_pend[c] = 1'b0;
            m_rs[c] = m_dir[c];
            exp_q.push_back({16'(cyc + 1), m_rs, m_dir[c], 2'(c)});
            m_last = c;
            m_next_grant = cyc + P + D + 1;
            m_busy_lo = cyc + 1;
            m_busy_hi = cyc + P + D;
        end
        if (v) begin
            m_pend[ch] = 1'b1;
            m_dir[ch] = st;
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_dir = '0;
        m_rs = '0;
        m_last = 3;
        m_next_grant = 0;
        m_busy_lo = 0;
        m_busy_hi = -1;
        exp_q.delete();
    endtask

    task automatic step(input logic v, input logic [1:0] ch, input logic st);
        req_valid = v;
        req_channel = ch;
        req_state = st;
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge(v, ch, st);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(m_pend == 0 && cyc > m_next_grant + 2) && n < 1000) begin
            step(1'b0, 2'd0, 1'b0);
            n++;
        end
        chk("drain_budget", int'(n < 1000), 1);
        chk("exp_q_empty", exp_q.size(), 0);
    endtask

    // Monitor: per-cycle invariants and status, pulse start/end scoring.
    bit in_pulse = 0;
    int p_start = 0;
    logic [3:0] p_drv = '0;
    logic [3:0] p_rs = '0;

    always @(negedge clk) begin
        logic [3:0] drv;
        logic [W-1:0] e;
        int ch_obs;
        if (started) begin
            drv = relay_a | relay_b;
            chk("onehot", int'($countones(drv) <= 1), 1);
            chk("ab_overlap", relay_a & relay_b, 0);
            chk("busy", busy, int'(cyc >= m_busy_lo && cyc <= m_busy_hi));
            chk("pending", pending, m_pend);
            if (!rst_n) begin
                in_pulse = 0;
            end else if (!in_pulse && drv != 0) begin
                in_pulse = 1;
                p_start = cyc;
                p_drv = drv;
                ch_obs = 0;
                for (int i = 0; i < 4; i++) if (drv[i]) ch_obs = i;
                obs_ch.push_back(ch_obs);
                obs_start.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", ch_obs, -1);
                    p_rs = relay_state;
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_start", cyc, int'(e[22:7]));
                    chk("pulse_ch", ch_obs, int'(e[1:0]));
                    chk("pulse_dir", int'(|relay_a), int'(e[2]));
                    p_rs = e[6:3];
                end
            end else if (in_pulse && drv == 0) begin
                in_pulse = 0;
                chk("pulse_len", cyc - p_start, P);
                chk("relay_state_after", relay_state, p_rs);
            end else if (in_pulse) begin
                chk("pulse_stable", drv, p_drv);
            end
        end
    end

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int s1;
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_relay_a", relay_a, 0);
        chk("rst_relay_b", relay_b, 0);
        chk("rst_relay_state", relay_state, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fsm", int'(fsm_state), int'(IDLE));
        rst_n = 1'b1;
        cyc = 0;
        started = 1;

        // Single request on ch2 sampled at edge 10.
        idle(9);
        step(1'b1, 2'd2, 1'b1);
        idle(9);
        chk("c19_relay_a", relay_a, 4'b0100);
        idle(1);
        chk("c20_relay_a", relay_a, 0);
        chk("c20_relay_state", relay_state, 4'b0100);
        idle(3);
        chk("c23_busy", busy, 1);
        idle(1);
        chk("c24_busy", busy, 0);
        drain();

        // Four consecutive strobes, one per channel.
        mark = obs_ch.size();
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'($urandom_range(0, 1)));
        drain();
        chk("all4_count", obs_ch.size() - mark, 4);
        for (int i = 0; i < 4; i++) chk("all4_order", obs_ch[mark + i], i);

        // Direction overwrite while pending: one pulse on ch1, B side.
        mark = obs_ch.size();
        step(1'b1, 2'd3, 1'b1);
        step(1'b1, 2'd1, 1'b1);
        idle(1);
        step(1'b1, 2'd1, 1'b0);
        drain();
        chk("overwrite_count", obs_ch.size() - mark, 2);
        chk("overwrite_ch", obs_ch[mark + 1], 1);
        chk("overwrite_state1", int'(relay_state[1]), 0);

        // Re-request ch0 during its own pulse.
        mark = obs_ch.size();
        step(1'b1, 2'd0, 1'b1);
        idle(3);
        step(1'b1, 2'd0, 1'b0);
        drain();
        chk("rereq_count", obs_ch.size() - mark, 2);
        s1 = obs_start[mark];
        chk("rereq_gap", obs_start[mark + 1] - s1, P + D + 1);

        // Round robin after ch2: ch3 before ch1.
        mark = obs_ch.size();
        step(1'b1, 2'd2, 1'b1);
        idle(2);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        drain();
        chk("rr_count", obs_ch.size() - mark, 3);
        chk("rr_first", obs_ch[mark + 1], 3);
        chk("rr_second", obs_ch[mark + 2], 1);

        // Request on the grant edge for the same channel.
        mark = obs_ch.size();
        step(1'b1, 2'd2, 1'b1);
        step(1'b1, 2'd2, 1'b0);
        drain();
        chk("grant_edge_count", obs_ch.size() - mark, 2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset in the middle of a pulse with another request queued.
        step(1'b1, 2'd1, 1'b1);
        n = 0;
        while ((relay_a | relay_b) == 0 && n < 20) begin
            step(1'b0, 2'd0, 1'b0);
            n++;
        end
        chk("rst_pulse_seen", int'(n < 20), 1);
        step(1'b1, 2'd2, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_relay_a", relay_a, 0);
        chk("midrst_relay_b", relay_b, 0);
        chk("midrst_pending", pending, 0);
        model_reset();
        idle(3);
        rst_n = 1'b1;
        mark = obs_ch.size();
        idle(40);
        chk("postrst_pulses", obs_ch.size() - mark, 0);
        chk("postrst_relay_state", relay_state, 0);
        chk("postrst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
